// File: rtl/fb_port_arbiter.sv
// Framebuffer BRAM arbiter: shares one single-port BRAM between the rasterizer
// (read/write), the display scanout (read only) and a built-in fill-colour clear engine.
module fb_port_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 24,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ras_req,
    input  logic                  ras_we,
    input  logic [ADDR_WIDTH-1:0] ras_addr,
    input  logic [DATA_WIDTH-1:0] ras_wdata,
    output logic                  ras_gnt,
    output logic                  ras_rvalid,
    output logic [DATA_WIDTH-1:0] ras_rdata,
    input  logic                  dsp_req,
    input  logic [ADDR_WIDTH-1:0] dsp_addr,
    output logic                  dsp_gnt,
    output logic                  dsp_rvalid,
    output logic [DATA_WIDTH-1:0] dsp_rdata,
    input  logic                  clr_start,
    input  logic [DATA_WIDTH-1:0] clr_color,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  bram_cen,
    output logic                  bram_wen,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    localparam int                    STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0]   STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDR_WIDTH-1:0]   r_clr_addr;
    logic [STARVE_W-1:0]     r_starve_cnt;
    logic [DATA_WIDTH-1:0]   r_clr_color;
    logic                    r_clr_done;
    logic                    r_ras_rvalid;
    logic                    r_dsp_rvalid;

    logic                    w_ras_gnt;
    logic                    w_dsp_gnt;
    logic                    w_clr_wr;
    logic                    w_starved;
    logic                    w_clr_last;

    assign w_starved  = (r_starve_cnt == STARVE_MAX);
    assign w_clr_last = (r_clr_addr == LAST_ADDR);

    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_ras_gnt    = 1'b0;
        w_dsp_gnt    = 1'b0;
        w_clr_wr     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ras_req && w_starved) begin
                    w_ras_gnt = 1'b1;
                end else if (dsp_req) begin
                    w_dsp_gnt = 1'b1;
                end else if (ras_req) begin
                    w_ras_gnt = 1'b1;
                end
                if (clr_start) begin
                    w_next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // Scanout is real-time, so it may stall the clear indefinitely.
                if (dsp_req) begin
                    w_dsp_gnt = 1'b1;
                end else begin
                    w_clr_wr = 1'b1;
                    if (w_clr_last) begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bram_cen  = ~(w_ras_gnt | w_dsp_gnt | w_clr_wr);
        bram_wen  = (w_ras_gnt & ras_we) | w_clr_wr;
        bram_addr = r_clr_addr;
        bram_din  = r_clr_color;
        if (w_ras_gnt) begin
            bram_addr = ras_addr;
            bram_din  = ras_wdata;
        end else if (w_dsp_gnt) begin
            bram_addr = dsp_addr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_clr_addr   <= '0;
            r_starve_cnt <= '0;
            r_clr_color  <= '0;
            r_clr_done   <= 1'b0;
            r_ras_rvalid <= 1'b0;
            r_dsp_rvalid <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_ras_rvalid <= w_ras_gnt & ~ras_we;
            r_dsp_rvalid <= w_dsp_gnt;
            r_clr_done   <= w_clr_wr & w_clr_last;
            if (w_clr_wr) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
            if (r_state == S_IDLE && clr_start) begin
                r_clr_color <= clr_color;
            end
            if (w_ras_gnt) begin
                r_starve_cnt <= '0;
            end else if (r_state == S_IDLE && ras_req && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    assign ras_gnt    = w_ras_gnt;
    assign dsp_gnt    = w_dsp_gnt;
    assign ras_rvalid = r_ras_rvalid;
    assign dsp_rvalid = r_dsp_rvalid;
    assign ras_rdata  = bram_dout;
    assign dsp_rdata  = bram_dout;
    assign clr_busy   = (r_state == S_CLEAR);
    assign clr_done   = r_clr_done;

endmodule
